host_cmd_sequencer: RTL and testbench
=====================================

# host_cmd_sequencer

Command-level controller between the DE1-SoC host word stream and the image-preprocessing datapath. It parses header words from the host and forwards payload bursts to the datapath. It also writes the debug-tap configuration word, pulses a soft reset into the datapath, and merges its own response words with datapath output onto the single host output stream.

## Interface
Parameters:
- `LEN_W`, 24, header length field width; at most 24.
- `RST_CYCLES`, 4, soft-reset pulse length in cycles; at least 1.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-high.
- `in_data`  in  32  host word.
- `in_valid`  in  1  host word present.
- `upstream_stall`  out  1  host must hold its word.
- `out_data`  out  32  word to host.
- `out_valid`  out  1  `out_data` valid.
- `downstream_stall`  in  1  host cannot accept the output word.
- `dut_in_data`  out  32  payload word to datapath.
- `dut_in_valid`  out  1  payload word valid.
- `dut_upstream_stall`  in  1  datapath stall.
- `dut_out_data`  in  32  datapath result.
- `dut_out_valid`  in  1  datapath result valid.
- `dut_downstream_stall`  out  1  stall to datapath output.
- `dut_reset`  out  1  datapath reset.
- `conf_data`  out  32  debug-tap configuration word.
- `conf_valid`  out  1  one-cycle write strobe for `conf_data`.

## Operation
- Input transfer occurs when `in_valid && !upstream_stall`.
- Output transfer occurs when `out_valid && !downstream_stall`.
- Header format: opcode is bits 31:28; length is bits LEN_W-1:0; the remaining bits are ignored.
- Opcodes:
  - 1 = STREAM
  - 2 = CONFIG
  - 3 = SOFT_RESET
  - 4 = STATUS
  - Any other opcode is BAD.
- States: IDLE, STREAM, CONFIG, SRST, RESP.
- IDLE:
  - `upstream_stall` = 0.
  - On a header transfer, latch opcode and length, then go to the state for that opcode.
  - STREAM with length 0 goes directly to RESP.
  - STATUS and BAD go directly to RESP.
- STREAM:
  - `dut_in_data` = `in_data`, `dut_in_valid` = `in_valid`, `upstream_stall` = `dut_upstream_stall`.
  - `remaining` decrements on each transfer.
  - The `total_words` counter (32-bit, wraps) increments on each transfer.
  - After the transfer with `remaining` == 1, go to RESP.
- CONFIG:
  - `upstream_stall` = 0.
  - On the next transfer, register the word into `conf_data`, then go to RESP.
  - `conf_valid` = 1 for exactly the following cycle.
- SRST:
  - `upstream_stall` = 1.
  - `dut_reset` = 1 for RST_CYCLES cycles, then go to RESP.
- RESP:
  - `upstream_stall` = 1, `dut_downstream_stall` = 1.
  - `out_data` = response word, `out_valid` = 1.
  - Go to IDLE on the output transfer.
- Outside RESP:
  - `out_data` = `dut_out_data`, `out_valid` = `dut_out_valid`, `dut_downstream_stall` = `downstream_stall`.
- Response words:
  - STREAM: {4'h1, 4'h0, number of words forwarded, 24 bits}.
  - CONFIG: {4'h2, 4'h0, `conf_data[23:0]`}.
  - SOFT_RESET: {4'h3, 28'h0}.
  - STATUS: {4'h4, 4'h0, `err_cnt[7:0]`, `total_words[15:0]`}.
  - BAD: {4'hE, 4'h0, header[23:0]}.
    - `err_cnt` (8-bit) saturates at 255.
- `dut_in_valid` = 0 in every state except STREAM.

## Timing
- Reset values:
  - State = IDLE; `out_valid`, `conf_valid`, `dut_in_valid` = 0; `conf_data` = 0.
  - `dut_reset` = 1 while `reset` is high.
  - `err_cnt`, `total_words`, `remaining` = 0.
  - `out_data` passes `dut_out_data` through.
- Reset asserted mid-operation aborts the command immediately. No response word is emitted, and any partially delivered burst is not completed.
- Header accepted in cycle N: the new state is active in cycle N+1. The datapath sees no payload before N+1.
- STREAM forwarding is zero-latency (combinational pass-through); the datapath's stall directly stalls the host.
- The last payload word transfers in cycle M: the response `out_valid` = 1 in cycle M+1 and holds stable through any `downstream_stall`.
- SOFT_RESET header in cycle N: `dut_reset` is high for cycles N+1 … N+RST_CYCLES, and the response appears in cycle N+RST_CYCLES+1.
- A datapath result pending on entry to RESP is held by `dut_downstream_stall`. It is sent after the response, never dropped or duplicated.
- `in_valid` while stalled: the word is held by the host and is not consumed.

## Structure
- Package `host_cmd_pkg` holds:
  - the opcode enum and the state enum;
  - the opcode field position, 31:28;
  - the response tag constants 4'h1–4'h4 and 4'hE.
- No sub-module. The RST_CYCLES counter, the length counter and the output mux are inline.
- The block instantiates nothing; the top level wires it to the datapath and the debug tap.

## Test plan
- Header 0x1000_0003, then words A, B, C, with `dut_upstream_stall` high for 2 cycles on B → datapath receives A, B, C in order with nothing extra; host output then shows 0x1000_0003 one cycle after C.
- Header 0x2000_0000, then 0x0000_0105 → `conf_valid` pulses once with `conf_data` = 0x0000_0105; response = 0x2000_0105.
- Header 0x3000_0000 with RST_CYCLES = 4 → `dut_reset` high for exactly 4 cycles and `upstream_stall` high throughout; response = 0x3000_0000.
- Header 0x7000_00AB, then header 0x4000_0000 → responses 0xE000_00AB, then 0x4001_0000 (`err_cnt` = 1, `total_words` = 0).
- `dut_out_valid` with value 0xDEAD_BEEF asserted while a STREAM response is pending, plus `downstream_stall` high for 3 cycles → host receives the response first, then 0xDEAD_BEEF exactly once.
- Reset pulsed in the middle of a 5-word STREAM → state returns to IDLE, no response is emitted, and the next header is parsed correctly.

Source files
------------

// File: rtl/host_cmd_pkg.sv
// Shared types and constants for the host command sequencer: opcodes, FSM states,
// header field positions and response tags.
package host_cmd_pkg;

  typedef enum logic [3:0] {
    OpStream    = 4'h1,
    OpConfig    = 4'h2,
    OpSoftReset = 4'h3,
    OpStatus    = 4'h4
  } opcode_e;

  typedef enum logic [2:0] {
    StIdle,
    StStream,
    StConfig,
    StSrst,
    StResp
  } state_e;

  localparam int unsigned OpMsb = 31;
  localparam int unsigned OpLsb = 28;

  localparam logic [3:0] TagStream    = 4'h1;
  localparam logic [3:0] TagConfig    = 4'h2;
  localparam logic [3:0] TagSoftReset = 4'h3;
  localparam logic [3:0] TagStatus    = 4'h4;
  localparam logic [3:0] TagBad       = 4'hE;

  function automatic logic op_known(input logic [3:0] op);
    return (op != 4'h0) && (op <= 4'h4);
  endfunction

endpackage

// File: rtl/host_cmd_sequencer.sv
// Parses host headers, forwards payload bursts to the datapath, drives the debug-tap
// config strobe and datapath soft reset, and merges response words onto the host stream.
module host_cmd_sequencer
  import host_cmd_pkg::*;
#(
  parameter int unsigned LEN_W      = 24,
  parameter int unsigned RST_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        upstream_stall,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        downstream_stall,
  output logic [31:0] dut_in_data,
  output logic        dut_in_valid,
  input  logic        dut_upstream_stall,
  input  logic [31:0] dut_out_data,
  input  logic        dut_out_valid,
  output logic        dut_downstream_stall,
  output logic        dut_reset,
  output logic [31:0] conf_data,
  output logic        conf_valid
);

  localparam int unsigned RstW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  // Only the low half of the word counter is ever reported, so the upper half is not kept.
  localparam int unsigned TotW = 16;

  state_e            state_q, state_d;
  logic [3:0]        opcode_q;
  logic [23:0]       hdr_lo_q;
  logic [LEN_W-1:0]  remaining_q;
  logic [RstW-1:0]   rst_cnt_q;
  logic [7:0]        err_cnt_q;
  logic [TotW-1:0]   total_words_q;
  logic [31:0]       conf_data_q;
  logic              conf_valid_q;
  logic              in_xfer;
  logic              out_xfer;
  logic [31:0]       resp_word;
  logic [3:0]        hdr_op;

  assign hdr_op   = in_data[OpMsb:OpLsb];
  assign in_xfer  = in_valid && !upstream_stall;
  assign out_xfer = out_valid && !downstream_stall;

  always_ff @(posedge clock) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (in_xfer) begin
          case (hdr_op)
            OpStream:    state_d = (in_data[LEN_W-1:0] == '0) ? StResp : StStream;
            OpConfig:    state_d = StConfig;
            OpSoftReset: state_d = StSrst;
            default:     state_d = StResp;
          endcase
        end
      end
      StStream: if (in_xfer && remaining_q == LEN_W'(1)) state_d = StResp;
      StConfig: if (in_xfer) state_d = StResp;
      StSrst:   if (rst_cnt_q == RstW'(RST_CYCLES - 1)) state_d = StResp;
      StResp:   if (out_xfer) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      opcode_q      <= '0;
      hdr_lo_q      <= '0;
      remaining_q   <= '0;
      rst_cnt_q     <= '0;
      err_cnt_q     <= '0;
      total_words_q <= '0;
      conf_data_q   <= '0;
      conf_valid_q  <= 1'b0;
    end else begin
      conf_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_xfer) begin
            opcode_q    <= hdr_op;
            hdr_lo_q    <= in_data[23:0];
            remaining_q <= in_data[LEN_W-1:0];
            rst_cnt_q   <= '0;
            if (!op_known(hdr_op) && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
          end
        end
        StStream: begin
          if (in_xfer) begin
            remaining_q   <= remaining_q - LEN_W'(1);
            total_words_q <= total_words_q + TotW'(1);
          end
        end
        StConfig: begin
          if (in_xfer) begin
            conf_data_q  <= in_data;
            conf_valid_q <= 1'b1;
          end
        end
        StSrst:  rst_cnt_q <= rst_cnt_q + RstW'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    case (opcode_q)
      OpStream:    resp_word = {TagStream, 4'h0, 24'(hdr_lo_q[LEN_W-1:0])};
      OpConfig:    resp_word = {TagConfig, 4'h0, conf_data_q[23:0]};
      OpSoftReset: resp_word = {TagSoftReset, 28'h0};
      OpStatus:    resp_word = {TagStatus, 4'h0, err_cnt_q, total_words_q};
      default:     resp_word = {TagBad, 4'h0, hdr_lo_q};
    endcase
  end

  always_comb begin
    upstream_stall       = 1'b0;
    dut_in_data          = in_data;
    dut_in_valid         = 1'b0;
    out_data             = dut_out_data;
    out_valid            = dut_out_valid && !reset;
    dut_downstream_stall = downstream_stall;
    dut_reset            = reset;
    unique case (state_q)
      StStream: begin
        dut_in_valid   = in_valid && !reset;
        upstream_stall = dut_upstream_stall;
      end
      StSrst: begin
        upstream_stall = 1'b1;
        dut_reset      = 1'b1;
      end
      StResp: begin
        upstream_stall       = 1'b1;
        dut_downstream_stall = 1'b1;
        out_data             = resp_word;
        out_valid            = !reset;
      end
      default: ;
    endcase
  end

  assign conf_data  = conf_data_q;
  assign conf_valid = conf_valid_q;

endmodule

// File: tb/tb_host_cmd_sequencer.sv
// Directed bench for host_cmd_sequencer: expected host and datapath words are queued
// as stimulus is driven and checked as the DUT hands them over.
module tb_host_cmd_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        upstream_stall;
  logic [31:0] out_data;
  logic        out_valid;
  logic        downstream_stall;
  logic [31:0] dut_in_data;
  logic        dut_in_valid;
  logic        dut_upstream_stall;
  logic [31:0] dut_out_data;
  logic        dut_out_valid;
  logic        dut_downstream_stall;
  logic        dut_reset;
  logic [31:0] conf_data;
  logic        conf_valid;

  host_cmd_sequencer #(.LEN_W(24), .RST_CYCLES(4)) dut (
    .clock                (clock),
    .reset                (reset),
    .in_data              (in_data),
    .in_valid             (in_valid),
    .upstream_stall       (upstream_stall),
    .out_data             (out_data),
    .out_valid            (out_valid),
    .downstream_stall     (downstream_stall),
    .dut_in_data          (dut_in_data),
    .dut_in_valid         (dut_in_valid),
    .dut_upstream_stall   (dut_upstream_stall),
    .dut_out_data         (dut_out_data),
    .dut_out_valid        (dut_out_valid),
    .dut_downstream_stall (dut_downstream_stall),
    .dut_reset            (dut_reset),
    .conf_data            (conf_data),
    .conf_valid           (conf_valid)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_out[$];
  logic [31:0] exp_dp[$];
  logic        dp_take = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every handshake on either output stream must match the next queued word.
  always @(negedge clock) begin
    dp_take = dut_out_valid && !dut_downstream_stall;
    if (dut_in_valid && !dut_upstream_stall) begin
      checks++;
      assert (exp_dp.size() != 0) else begin
        errors++;
        $error("FAIL dp_unexpected observed=%h expected=none", dut_in_data);
      end
      if (exp_dp.size() != 0) check("dp_word", dut_in_data, exp_dp.pop_front());
    end
    if (out_valid && !downstream_stall) begin
      checks++;
      assert (exp_out.size() != 0) else begin
        errors++;
        $error("FAIL out_unexpected observed=%h expected=none", out_data);
      end
      if (exp_out.size() != 0) check("out_word", out_data, exp_out.pop_front());
    end
  end

  // Datapath result source: drops its valid once the word has been taken.
  always @(posedge clock) begin
    if (dp_take) begin
      #1;
      dut_out_valid = 1'b0;
    end
  end

  task automatic send(input logic [31:0] w);
    int n = 0;
    in_data  = w;
    in_valid = 1'b1;
    @(negedge clock);
    while (upstream_stall && n < 50) begin
      @(negedge clock);
      n++;
    end
    checks++;
    assert (!upstream_stall) else begin
      errors++;
      $error("FAIL send_timeout observed=stalled expected=accepted word=%h", w);
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    do begin
      @(posedge clock);
      n++;
    end while ((exp_out.size() != 0 || exp_dp.size() != 0) && n < 60);
    #1;
    checks++;
    assert (exp_out.size() == 0 && exp_dp.size() == 0) else begin
      errors++;
      $error("FAIL drain observed=%0d/%0d pending expected=0/0", exp_out.size(), exp_dp.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; downstream_stall = 1'b0;
    dut_upstream_stall = 1'b0; dut_out_valid = 1'b0; dut_out_data = 32'h1234_5678;

    // Reset state
    @(posedge clock); #1;
    @(negedge clock);
    check("rst_dut_reset", 32'(dut_reset), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_conf_valid", 32'(conf_valid), 32'd0);
    check("rst_dut_in_valid", 32'(dut_in_valid), 32'd0);
    check("rst_conf_data", conf_data, 32'h0);
    check("rst_out_data", out_data, 32'h1234_5678);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("idle_stall", 32'(upstream_stall), 32'd0);
    check("idle_dut_reset", 32'(dut_reset), 32'd0);
    @(posedge clock); #1;

    // BAD opcode then STATUS
    exp_out.push_back(32'hE000_00AB);
    exp_out.push_back(32'h4001_0000);
    send(32'h7000_00AB);
    send(32'h4000_0000);
    drain();

    // STREAM of 3 with a 2-cycle datapath stall on B
    exp_dp.push_back(32'hAAAA_0001);
    exp_dp.push_back(32'hBBBB_0002);
    exp_dp.push_back(32'hCCCC_0003);
    exp_out.push_back(32'h1000_0003);
    send(32'h1000_0003);
    send(32'hAAAA_0001);
    in_data = 32'hBBBB_0002; in_valid = 1'b1; dut_upstream_stall = 1'b1;
    repeat (2) begin
      @(negedge clock);
      check("stream_stall_pass", 32'(upstream_stall), 32'd1);
      @(posedge clock); #1;
    end
    dut_upstream_stall = 1'b0;
    send(32'hBBBB_0002);
    send(32'hCCCC_0003);
    @(negedge clock);
    check("stream_resp_valid", 32'(out_valid), 32'd1);
    check("stream_resp_data", out_data, 32'h1000_0003);
    drain();

    // CONFIG
    exp_out.push_back(32'h2000_0105);
    send(32'h2000_0000);
    send(32'h0000_0105);
    @(negedge clock);
    check("conf_valid_pulse", 32'(conf_valid), 32'd1);
    check("conf_data", conf_data, 32'h0000_0105);
    @(posedge clock); #1;
    @(negedge clock);
    check("conf_valid_drop", 32'(conf_valid), 32'd0);
    drain();

    // SOFT_RESET
    exp_out.push_back(32'h3000_0000);
    send(32'h3000_0000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("srst_dut_reset", 32'(dut_reset), 32'd1);
      check("srst_stall", 32'(upstream_stall), 32'd1);
      @(posedge clock); #1;
    end
    @(negedge clock);
    check("srst_dut_reset_end", 32'(dut_reset), 32'd0);
    check("srst_resp_valid", 32'(out_valid), 32'd1);
    check("srst_resp_data", out_data, 32'h3000_0000);
    drain();

    // Datapath result pending while a STREAM response waits behind downstream_stall
    exp_dp.push_back(32'h0000_0055);
    exp_out.push_back(32'h1000_0001);
    exp_out.push_back(32'hDEAD_BEEF);
    send(32'h1000_0001);
    downstream_stall = 1'b1; dut_out_valid = 1'b1; dut_out_data = 32'hDEAD_BEEF;
    send(32'h0000_0055);
    repeat (3) begin
      @(negedge clock);
      check("hold_resp_data", out_data, 32'h1000_0001);
      check("hold_resp_valid", 32'(out_valid), 32'd1);
      check("hold_dp_stall", 32'(dut_downstream_stall), 32'd1);
      @(posedge clock); #1;
    end
    downstream_stall = 1'b0;
    drain();
    @(negedge clock);
    check("merge_no_dup", 32'(out_valid), 32'd0);
    @(posedge clock); #1;

    // STATUS reflects one error and four forwarded words
    exp_out.push_back(32'h4001_0004);
    send(32'h4000_0000);
    drain();

    // Reset in the middle of a 5-word burst
    exp_dp.push_back(32'h0000_0011);
    exp_dp.push_back(32'h0000_0022);
    send(32'h1000_0005);
    send(32'h0000_0011);
    send(32'h0000_0022);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_dut_reset", 32'(dut_reset), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("postrst_stall", 32'(upstream_stall), 32'd0);
    check("postrst_out_valid", 32'(out_valid), 32'd0);
    check("postrst_dut_in_valid", 32'(dut_in_valid), 32'd0);
    @(posedge clock); #1;
    exp_out.push_back(32'h4000_0000);
    send(32'h4000_0000);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
